// File: rtl/crc_strip_fifo.sv
// crc_strip_fifo: packet FIFO for the USB RX data path.
// Queues decoder bytes for the AES datapath and strips the trailing HOLD bytes
// (the CRC16 field) of every packet. A HOLD-deep holdback register hides the
// newest bytes from the reader until a following byte proves they are payload.
// Reports runt packets, dropped writes (sticky overflow) and occupancy.
// Optional feature macro: CRC_STRIP_FIFO_CRC_CHECK_EN enables a USB CRC16
// residue check whose result (crc_ok) is valid while pkt_done is high.

module crc_strip_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int HOLD   = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              w_enable,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_eop,
    input  logic              r_enable,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic              overflow,
    output logic              crc_ok
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int HCNT_W = $clog2(HOLD + 1);

    logic [DATA_W-1:0] mem  [DEPTH];
    logic [DATA_W-1:0] hold [HOLD];
    logic [HCNT_W-1:0] hcnt;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [CNT_W-1:0]  count_nxt;

    logic wr_acc;
    logic hold_full;
    logic push;
    logic pop;
    logic pkt_end;
    logic long_pkt;

    // Handshake decode: full/empty are the registered flags from the start of the cycle.
    assign wr_acc    = w_enable & ~full;
    assign hold_full = (hcnt == HCNT_W'(HOLD));
    assign push      = wr_acc & hold_full;
    assign pop       = r_enable & ~empty;
    assign pkt_end   = wr_acc & w_eop;
    // The packet reaches HOLD bytes if the holdback is (or becomes) full with this byte.
    assign long_pkt  = hold_full | (hcnt == HCNT_W'(HOLD - 1));

    // First-word fall-through head; forced to zero when nothing is readable.
    assign r_data = empty ? '0 : mem[rptr];

    // Next occupancy from the storage push/pop pair.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Payload storage and holdback shift register; contents are qualified by pointers and hcnt.
    always_ff @(posedge clk) begin
        // NOTE: data arrays carry no reset; validity is tracked by pointers/counters, which are reset.
        if (push) begin
            mem[wptr] <= hold[0];
        end
        if (wr_acc) begin
            for (int i = 0; i < HOLD - 1; i++) begin
                hold[i] <= hold[i + 1];
            end
            hold[HOLD-1] <= w_data;
        end
    end

    // Control state: pointers, flags, holdback occupancy and end-of-packet pulses.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!n_rst || clear) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            hcnt     <= '0;
            overflow <= 1'b0;
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + ADDR_W'(1);
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNT_W'(DEPTH));

            if (wr_acc) begin
                if (w_eop) begin
                    hcnt <= '0;
                end else if (!hold_full) begin
                    hcnt <= hcnt + HCNT_W'(1);
                end
            end

            if (w_enable && full) begin
                overflow <= 1'b1;
            end
            pkt_done <= pkt_end & long_pkt;
            pkt_err  <= pkt_end & ~long_pkt;
        end
    end

`ifdef CRC_STRIP_FIFO_CRC_CHECK_EN
    logic [15:0] crc;
    logic [15:0] crc_nxt;

    // Reflected CRC16 (poly 0xA001), one data bit per step, LSB first.
    function automatic logic [15:0] crc_update(input logic [15:0] c, input logic [DATA_W-1:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < DATA_W; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
        end
        return r;
    endfunction

    assign crc_nxt = crc_update(crc, w_data);

    // Running CRC over each packet; a good USB packet leaves residue 0xB001.
    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            crc    <= 16'hFFFF;
            crc_ok <= 1'b0;
        end else begin
            crc_ok <= pkt_end & long_pkt & (crc_nxt == 16'hB001);
            if (pkt_end) begin
                crc <= 16'hFFFF;
            end else if (wr_acc) begin
                crc <= crc_nxt;
            end
        end
    end
`else
    assign crc_ok = 1'b0;
`endif

endmodule
